cart_rom_fetch: RTL and testbench
=================================

# cart_rom_fetch

Cartridge ROM read engine sitting between a mapper's translated `mem_addr` and the SDRAM controller. It turns CPU cartridge reads into 4-word SDRAM bursts and keeps the last burst in a one-line, 8-byte buffer. It stalls the Z80 via `wait_n` on a miss and returns the addressed byte. Reads beyond `rom_size` never reach SDRAM and return `8'hFF`.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cs`  in  1  cartridge slot selected
- `rd`  in  1  CPU read strobe
- `mem_addr`  in  25  byte address from mapper
- `rom_size`  in  25  loaded ROM size in bytes
- `flush`  in  1  invalidate line buffer (ROM reload / slot change)
- `d_to_cpu`  out  8  read data to CPU
- `wait_n`  out  1  CPU wait; low stalls the access
- `sdram_addr`  out  25  burst start address, 8-byte aligned
- `sdram_req`  out  1  burst request, level, held until ack
- `sdram_ack`  in  1  one-cycle pulse: request accepted
- `sdram_valid`  in  1  one-cycle pulse per returned word
- `sdram_dout`  in  16  returned word, low byte = even address

## Operation
- Access: `acc = cs & rd`.
- Out of range: `oor = (mem_addr >= rom_size)`.
  - `rom_size == 0` makes every access out of range.
- Hit: `hit = line_valid & (mem_addr[24:3] == tag)`.
- Byte select: word `line[mem_addr[2:1]]`; byte is low if `mem_addr[0] == 0`, high otherwise.
- `d_to_cpu` is combinational:
  - `8'hFF` if `oor`;
  - selected byte if `hit`;
  - otherwise `8'hFF`.
- `wait_n` is combinational: `wait_n = !(acc & !oor & !hit)`.
- FSM states IDLE, REQ, FILL:
  - IDLE:
    - If `acc & !oor & !hit`: latch `tag <= mem_addr[24:3]`, clear `line_valid`, load `sdram_addr <= {mem_addr[24:3], 3'b000}`, go to REQ.
    - All `sdram_valid` pulses are ignored in IDLE.
  - REQ:
    - `sdram_req = 1`.
    - On `sdram_ack`: drop `sdram_req` next cycle, clear `widx`, go to FILL.
  - FILL:
    - Each `sdram_valid` writes `line[widx] <= sdram_dout` and increments the 2-bit `widx`.
    - On the 4th valid: set `line_valid` (unless a flush is pending), go to IDLE.
- `flush`:
  - In IDLE or REQ: clears `line_valid` immediately.
  - In FILL: sets `flush_pend`. Completion then leaves `line_valid = 0` and clears `flush_pend`.
- CPU address change while in REQ/FILL has no effect on the burst. On return to IDLE the current address is re-evaluated (hit, or new miss).
- Reset values:
  - State IDLE.
  - `sdram_req = 0`, `sdram_addr = 0`, `tag = 0`.
  - `line_valid = 0`, `flush_pend = 0`, `widx = 0`.
  - Line words `16'hFFFF`.
  - Outputs with no access: `wait_n = 1`, `d_to_cpu = 8'hFF`.
- Reset mid-burst: SDRAM words still in flight are discarded because IDLE ignores `sdram_valid`.

## Timing
- Hit and out-of-range reads: zero added latency; data valid in the same cycle `acc` is high, `wait_n` stays high.
- Miss sequence (N = cycle `acc` first seen):
  - `wait_n` low at N (combinational).
  - `sdram_req` high from N+1 through the `sdram_ack` cycle.
  - 4 valid pulses at any spacing.
  - `line_valid` is set on the edge ending the 4th valid cycle; `wait_n` rises and data appears in the following cycle.
- Minimum miss: ack at N+1, valids at N+2..N+5, `wait_n` high at N+6.
- `sdram_ack` arriving outside REQ is ignored.
- `sdram_addr` is stable from N+1 until the next miss.
- Flush and 4th valid in the same cycle: flush wins, `line_valid = 0`.

## Test plan
- Reset with `acc = 0`:
  - `wait_n = 1`, `d_to_cpu = FF`, `sdram_req = 0`.
- Miss at `mem_addr = 0x0000005`, `rom_size = 0x8000`:
  - `sdram_addr = 0x0000000`, `sdram_req` high N+1..ack.
  - Words `0x1100, 0x3322, 0x5544, 0x7766` → `wait_n` high, `d_to_cpu = 0x55`.
  - Then `mem_addr = 0x0000007` → `0x77` with no SDRAM request.
- `mem_addr = 0x0008000`, `rom_size = 0x8000`:
  - `d_to_cpu = FF`, `wait_n = 1`, no `sdram_req`.
  - Repeat with `rom_size = 0`: same result.
- Miss, then `flush` pulsed during the 2nd valid:
  - Burst completes and FSM returns to IDLE with `line_valid = 0`.
  - Held read issues a second burst to the same `sdram_addr`.
- Stray `sdram_valid`/`sdram_ack` pulses in IDLE:
  - Line contents and state unchanged; a subsequent hit returns the original data.
- `reset_n` asserted after 2 of 4 valids:
  - All state at reset values immediately.
  - Remaining 2 valids ignored; the next read re-requests the burst.

Source files
------------

// File: rtl/cart_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module   : cart_rom_fetch
// Purpose  : Cartridge ROM read engine. Fetches 4-word SDRAM bursts into a
//            one-line 8-byte buffer and stalls the CPU on a miss.
// Revision : 1.0 - initial release
// ============================================================================
module cart_rom_fetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        rd,
  input  logic [24:0] mem_addr,
  input  logic [24:0] rom_size,
  input  logic        flush,
  output logic [7:0]  d_to_cpu,
  output logic        wait_n,
  output logic [24:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_valid,
  input  logic [15:0] sdram_dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [21:0] r_tag;
  logic        r_line_valid;
  logic        r_flush_pend;
  logic [1:0]  r_widx;
  logic [15:0] r_line [4];
  logic [24:0] r_sdram_addr;

  logic        w_acc;
  logic        w_oor;
  logic        w_hit;
  logic        w_miss;
  logic        w_last_valid;
  logic [15:0] w_word;
  logic [7:0]  w_byte;

  assign w_acc        = cs & rd;
  assign w_oor        = (mem_addr >= rom_size);
  assign w_hit        = r_line_valid & (mem_addr[24:3] == r_tag);
  assign w_miss       = w_acc & ~w_oor & ~w_hit;
  assign w_last_valid = sdram_valid & (r_widx == 2'd3);

  assign w_word   = r_line[mem_addr[2:1]];
  assign w_byte   = mem_addr[0] ? w_word[15:8] : w_word[7:0];
  assign d_to_cpu = (!w_oor && w_hit) ? w_byte : 8'hFF;
  assign wait_n   = ~w_miss;

  assign sdram_req  = (r_state == S_REQ);
  assign sdram_addr = r_sdram_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_miss)       w_next_state = S_REQ;
      S_REQ:   if (sdram_ack)    w_next_state = S_FILL;
      S_FILL:  if (w_last_valid) w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  // A flush seen during FILL is held so the completing burst cannot mark
  // stale data valid; a flush on the final word wins as well.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag        <= '0;
      r_line_valid <= 1'b0;
      r_flush_pend <= 1'b0;
      r_widx       <= 2'd0;
      r_sdram_addr <= '0;
      for (int i = 0; i < 4; i++) r_line[i] <= 16'hFFFF;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_tag        <= mem_addr[24:3];
            r_line_valid <= 1'b0;
            r_sdram_addr <= {mem_addr[24:3], 3'b000};
          end else if (flush) begin
            r_line_valid <= 1'b0;
          end
        end
        S_REQ: begin
          if (flush)     r_line_valid <= 1'b0;
          if (sdram_ack) r_widx       <= 2'd0;
        end
        S_FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (sdram_valid) begin
            r_line[r_widx] <= sdram_dout;
            r_widx         <= r_widx + 2'd1;
            if (r_widx == 2'd3) begin
              r_line_valid <= ~(flush | r_flush_pend);
              r_flush_pend <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cart_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cart_rom_fetch
// Purpose  : Self-checking bench for cart_rom_fetch with a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cart_rom_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs, rd, flush;
  logic [24:0] mem_addr, rom_size;
  logic [7:0]  d_to_cpu;
  logic        wait_n;
  logic [24:0] sdram_addr;
  logic        sdram_req, sdram_ack, sdram_valid;
  logic [15:0] sdram_dout;

  int checks = 0;
  int errors = 0;

  // Reference model: one cached 8-byte line, byte addressable
  bit          m_valid = 0;
  logic [21:0] m_tag = '0;
  logic [7:0]  m_bytes [8];

  cart_rom_fetch dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .rd(rd), .mem_addr(mem_addr),
    .rom_size(rom_size), .flush(flush), .d_to_cpu(d_to_cpu), .wait_n(wait_n),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_valid(sdram_valid), .sdram_dout(sdram_dout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the first REQ cycle; returns in the cycle after the 4th word.
  task automatic burst(input logic [24:0] a, input int flush_at,
                       input bit use_fw, input logic [63:0] fw);
    int d;
    int gap;
    logic [15:0] w;
    #1;
    d = $urandom_range(0, 3);
    repeat (d) begin
      chk("req_hold", sdram_req, 1);
      chk("wait_in_req", wait_n, 0);
      cyc(); #1;
    end
    chk("req", sdram_req, 1);
    chk("sdram_addr", sdram_addr, {a[24:3], 3'b000});
    sdram_ack = 1'b1;
    cyc();
    sdram_ack = 1'b0;
    #1;
    chk("req_drop", sdram_req, 0);
    for (int k = 0; k < 4; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        #1;
        chk("wait_in_fill", wait_n, 0);
        cyc();
      end
      w = use_fw ? fw[16*k +: 16] : 16'($urandom);
      sdram_valid = 1'b1;
      sdram_dout  = w;
      if (k + 1 == flush_at) flush = 1'b1;
      m_bytes[2*k]   = w[7:0];
      m_bytes[2*k+1] = w[15:8];
      cyc();
      sdram_valid = 1'b0;
      flush       = 1'b0;
      sdram_dout  = 16'($urandom);
    end
    m_valid = (flush_at == 0);
    m_tag   = a[24:3];
  endtask

  task automatic read(input logic [24:0] a, input int flush_at,
                      input bit use_fw, input logic [63:0] fw);
    bit oor, hit;
    cs = 1'b1; rd = 1'b1; mem_addr = a;
    #1;
    oor = (a >= rom_size);
    hit = m_valid && (m_tag == a[24:3]);
    if (!oor && !hit) begin
      chk("miss_wait", wait_n, 0);
      chk("miss_req_n", sdram_req, 0);
      m_valid = 0;
      cyc();
      burst(a, flush_at, use_fw, fw);
      if (flush_at != 0) begin
        #1;
        chk("reissue_wait", wait_n, 0);
        chk("reissue_req_n", sdram_req, 0);
        cyc();
        burst(a, 0, use_fw, fw);
      end
      #1;
    end
    chk("rd_wait", wait_n, 1);
    chk("rd_data", d_to_cpu, oor ? 8'hFF : m_bytes[a[2:0]]);
    chk("rd_req", sdram_req, 0);
    cyc();
  endtask

  initial begin
    logic [24:0] a;
    logic [24:0] ra;
    reset_n = 1'b0; cs = 0; rd = 0; flush = 0; mem_addr = '0; rom_size = '0;
    sdram_ack = 0; sdram_valid = 0; sdram_dout = '0;
    for (int i = 0; i < 8; i++) m_bytes[i] = 8'hFF;
    #1;
    chk("rst_wait", wait_n, 1);
    chk("rst_data", d_to_cpu, 8'hFF);
    chk("rst_req", sdram_req, 0);
    chk("rst_addr", sdram_addr, 0);
    cyc(); cyc();
    reset_n = 1'b1;
    rom_size = 25'h8000;
    cyc();

    // Directed miss with known words, then a hit in the same line
    read(25'h5, 0, 1, 64'h7766_5544_3322_1100);
    mem_addr = 25'h5; #1;
    chk("dir_byte5", d_to_cpu, 8'h55);
    read(25'h7, 0, 0, 0);
    mem_addr = 25'h7; #1;
    chk("dir_byte7", d_to_cpu, 8'h77);

    // Out of range, including empty ROM
    read(25'h8000, 0, 0, 0);
    rom_size = 25'h0;
    read(25'h0, 0, 0, 0);
    rom_size = 25'h8000;

    // Randomised reads: mostly a small window for hits, some out of range
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) ra = 25'h8000 + 25'($urandom_range(0, 255));
      else                           ra = 25'($urandom_range(0, 31));
      read(ra, 0, 0, 0);
      if ($urandom_range(0, 2) == 0) begin
        cs = 1'b0; #1;
        chk("idle_wait", wait_n, 1);
        cyc();
      end
    end

    // Flush during the 2nd word and on the 4th word
    read(25'h123, 2, 0, 0);
    read(25'h2A1, 4, 0, 0);

    // Flush while idle invalidates the line
    a = 25'h2A2;
    read(a, 0, 0, 0);
    cs = 1'b0; flush = 1'b1; cyc(); flush = 1'b0;
    m_valid = 0;
    read(a, 0, 0, 0);

    // Stray SDRAM pulses in IDLE are ignored
    cs = 1'b0;
    repeat (3) begin
      sdram_valid = 1'b1; sdram_ack = 1'b1; sdram_dout = 16'($urandom);
      cyc();
    end
    sdram_valid = 1'b0; sdram_ack = 1'b0;
    #1;
    chk("stray_req", sdram_req, 0);
    read(a + 25'd3, 0, 0, 0);

    // Reset after 2 of 4 words
    a = 25'h4C8;
    cs = 1'b1; rd = 1'b1; mem_addr = a;
    cyc();
    sdram_ack = 1'b1; cyc(); sdram_ack = 1'b0;
    sdram_valid = 1'b1; sdram_dout = 16'hABCD; cyc();
    sdram_dout = 16'h1234; cyc();
    sdram_valid = 1'b0;
    reset_n = 1'b0; cs = 1'b0;
    #1;
    chk("mid_rst_req", sdram_req, 0);
    chk("mid_rst_addr", sdram_addr, 0);
    chk("mid_rst_wait", wait_n, 1);
    chk("mid_rst_data", d_to_cpu, 8'hFF);
    m_valid = 0;
    for (int i = 0; i < 8; i++) m_bytes[i] = 8'hFF;
    cyc();
    reset_n = 1'b1;
    sdram_valid = 1'b1; sdram_dout = 16'h5A5A; cyc(); cyc();
    sdram_valid = 1'b0;
    #1;
    chk("post_rst_req", sdram_req, 0);
    read(a, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
